// File: rtl/camera_ctrl.sv
// camera_ctrl: captures one frame of FRAME_LEN bytes from a camera into a
// local register buffer, then streams the frame out over a valid/ready
// handshake. Abort cancels the frame at any point; err is a sticky flag for
// camera bytes that arrive when the block is not able to store them.
module camera_ctrl #(
  parameter int unsigned FRAME_LEN = 12,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              camera_en,
  input  logic              cam_valid,
  input  logic [DATA_W-1:0] cam_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [7:0]        frame_cnt
);

  // Pointer/counter width must hold the value FRAME_LEN itself (the "full"
  // marker); buffer index width only needs to address FRAME_LEN entries.
  localparam int unsigned PW = $clog2(FRAME_LEN + 1);
  localparam int unsigned IW = $clog2(FRAME_LEN);

  localparam logic [PW-1:0] LEN_P  = PW'(FRAME_LEN);
  localparam logic [PW-1:0] LAST_P = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] ONE_P  = PW'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]        state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     en_cnt;
  logic [DATA_W-1:0] frame_buf [FRAME_LEN];

  logic abort_now;
  logic cap_ok;
  logic wr_en;
  logic wr_last;
  logic rd_acc;
  logic rd_last;

  // Qualified events shared by the state machine, buffer and error flag.
  always_comb begin
    abort_now = abort && (state != IDLE);
    cap_ok    = (state == CAPTURE) && (wr_ptr != LEN_P);
    wr_en     = cap_ok && cam_valid && !abort;
    wr_last   = wr_en && (wr_ptr == LAST_P);
    rd_acc    = (state == DRAIN) && out_ready && !abort;
    rd_last   = rd_acc && (rd_ptr == LAST_P);
  end

  // Frame state machine, camera enable window, pointers and frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      camera_en <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      en_cnt    <= '0;
      frame_cnt <= '0;
    end else if (abort_now) begin
      state     <= IDLE;
      camera_en <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      en_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CAPTURE;
            camera_en <= 1'b1;
            // The cycle that starts on this edge is the first enabled cycle.
            en_cnt    <= ONE_P;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
          end
        end
        CAPTURE: begin
          if (camera_en) begin
            if (en_cnt == LEN_P) begin
              camera_en <= 1'b0;
            end else begin
              en_cnt <= en_cnt + ONE_P;
            end
          end
          if (wr_en) begin
            wr_ptr <= wr_ptr + ONE_P;
          end
          if (wr_last) begin
            state     <= DRAIN;
            rd_ptr    <= '0;
            camera_en <= 1'b0;
            en_cnt    <= '0;
          end
        end
        DRAIN: begin
          if (rd_last) begin
            state  <= DONE;
            rd_ptr <= '0;
          end else if (rd_acc) begin
            rd_ptr <= rd_ptr + ONE_P;
          end
        end
        DONE: begin
          state     <= IDLE;
          wr_ptr    <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end
        default: begin
          state     <= IDLE;
          camera_en <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      frame_buf[wr_ptr[IW-1:0]] <= cam_data;
    end
  end

  // Sticky error: any camera byte that cannot be stored; cleared by a new start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (cam_valid && !cap_ok) begin
      err <= 1'b1;
    end else if ((state == IDLE) && start) begin
      err <= 1'b0;
    end
  end

  // Output stage is decoded from state so data holds naturally during stalls;
  // frame_done is masked by abort so a cancelled DONE never reports a frame.
  always_comb begin
    out_valid  = (state == DRAIN);
    out_data   = out_valid ? frame_buf[rd_ptr[IW-1:0]] : '0;
    out_last   = out_valid && (rd_ptr == LAST_P);
    busy       = (state != IDLE);
    frame_done = (state == DONE) && !abort;
  end

endmodule

// File: tb/tb_camera_ctrl.sv
// tb_camera_ctrl: randomized and directed frames against a queue-based
// reference model; a monitor process scores every accepted output byte.
`timescale 1ns/1ps
module tb_camera_ctrl;

  localparam int unsigned FRAME_LEN = 12;
  localparam int unsigned DATA_W    = 8;

  typedef struct {
    logic [DATA_W-1:0] d;
    bit                last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic              camera_en;
  logic              cam_valid;
  logic [DATA_W-1:0] cam_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              frame_done;
  logic              err;
  logic [7:0]        frame_cnt;

  camera_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .DATA_W    (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .camera_en  (camera_en),
    .cam_valid  (cam_valid),
    .cam_data   (cam_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned       vectors    = 0;
  int unsigned       miscompares = 0;
  exp_t              exp_q[$];
  logic [DATA_W-1:0] cam_q[$];
  logic [DATA_W-1:0] dir_bytes [FRAME_LEN];
  int unsigned       done_count = 0;
  bit                mon_en     = 0;
  bit                inject     = 0;
  int unsigned       rdy_mode   = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Camera model: a byte appears the cycle after each enabled cycle.
  initial begin : camera
    logic en_s;
    cam_valid = 1'b0;
    cam_data  = '0;
    forever begin
      @(negedge clk);
      en_s = camera_en;
      @(posedge clk);
      #1;
      if (en_s || inject) begin
        cam_valid = 1'b1;
        cam_data  = (cam_q.size() != 0) ? cam_q.pop_front() : DATA_W'($urandom);
        inject    = 0;
      end else begin
        cam_valid = 1'b0;
      end
    end
  end

  // Downstream ready: always, 1-0-0 pattern, or random.
  initial begin : ready_gen
    int unsigned phase = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (phase == 0);
          phase = (phase + 1) % 3;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scores accepted bytes, stall stability, frame_done and frame_cnt.
  initial begin : monitor
    bit                pending_done = 0;
    bit                stall_prev   = 0;
    logic [DATA_W-1:0] data_prev    = '0;
    bit                prev_rst_low = 0;
    bit                prev_abort   = 0;
    bit                prev_busy    = 0;
    int unsigned       cnt_m        = 0;
    int unsigned       en_run       = 0;
    exp_t              e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_rst_low) begin
          cnt_m        = 0;
          pending_done = 0;
          stall_prev   = 0;
          en_run       = 0;
        end
        if (prev_abort && prev_busy) begin
          pending_done = 0;
          stall_prev   = 0;
        end
        check("frame_done", int'(frame_done), int'(pending_done));
        check("frame_cnt", int'(frame_cnt), int'(cnt_m));
        if (stall_prev) begin
          check("stall_valid", int'(out_valid), 1);
          check("stall_data", int'(out_data), int'(data_prev));
        end
        if (camera_en) check("valid_during_en", int'(out_valid), 0);
        if (frame_done) begin
          cnt_m = (cnt_m + 1) % 256;
          done_count++;
        end
        if (camera_en) begin
          en_run++;
        end else if (en_run != 0) begin
          if (!prev_abort && !prev_rst_low) check("en_cycles", int'(en_run), int'(FRAME_LEN));
          en_run = 0;
        end
        pending_done = 0;
        if (out_valid && out_ready && rst_n && !abort) begin
          if (exp_q.size() == 0) begin
            check("byte_expected", int'(exp_q.size() != 0), 1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'(out_data), int'(e.d));
            check("out_last", int'(out_last), int'(e.last));
            pending_done = e.last;
          end
        end
        stall_prev = out_valid && !out_ready && rst_n && !abort;
        data_prev  = out_data;
      end
      prev_rst_low = !rst_n;
      prev_abort   = abort;
      prev_busy    = busy;
    end
  end

  task automatic check_reset_outputs();
    check("rst_camera_en", int'(camera_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_err", int'(err), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
  endtask

  // One frame: load camera, predict output, pulse start, check latency,
  // then wait (bounded) for the frame to finish.
  task automatic run_frame(input bit directed, input bit extra_start,
                           input int abort_at, input int rst_at);
    logic [DATA_W-1:0] b [FRAME_LEN];
    int unsigned d0;
    bit got;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      b[i] = directed ? dir_bytes[i] : DATA_W'($urandom);
    end
    cam_q.delete();
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      cam_q.push_back(b[i]);
      if (abort_at < 0) exp_q.push_back('{d: b[i], last: (i == int'(FRAME_LEN) - 1)});
    end
    d0 = done_count;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_clear_on_start", int'(err), 0);
    check("busy_on_start", int'(busy), 1);
    check("camera_en_on_start", int'(camera_en), 1);
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      tick();
      if (extra_start) start = (i == 3);
      if (abort_at >= 0 && i == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_camera_en", int'(camera_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        repeat (3) tick();
        check("abort_stray_err", int'(err), 1);
        check("abort_no_done", int'(done_count - d0), 0);
        cam_q.delete();
        return;
      end
    end
    check("valid_before_latency", int'(out_valid), 0);
    tick();
    check("valid_at_latency", int'(out_valid), 1);
    if (rst_at >= 0) begin
      repeat (rst_at) tick();
      rst_n = 1'b0;
      tick();
      check_reset_outputs();
      rst_n = 1'b1;
      exp_q.delete();
      cam_q.delete();
      return;
    end
    if (extra_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    got = 0;
    for (int t = 0; t < 400 && !got; t++) begin
      tick();
      got = (done_count != d0);
    end
    check("frame_done_seen", int'(got), 1);
    check("idle_after_done", int'(busy), 0);
    check("single_done", int'(done_count - d0), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [8*FRAME_LEN-1:0] dir_packed;
    dir_packed = 96'hBC2781FFCE1FE0A9382BD411;
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      dir_bytes[i] = dir_packed[8*(FRAME_LEN-1-i) +: 8];
    end
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    rst_n  = 1'b1;
    mon_en = 1;
    tick();

    rdy_mode = 0;
    run_frame(1, 0, -1, -1);
    check("directed_err", int'(err), 0);
    check("directed_cnt", int'(frame_cnt), 1);

    rdy_mode = 1;
    run_frame(1, 0, -1, -1);

    rdy_mode = 2;
    run_frame(0, 1, -1, -1);
    rdy_mode = 1;
    run_frame(0, 1, -1, -1);

    rdy_mode = 0;
    run_frame(0, 0, 5, -1);
    check("abort_cnt_kept", int'(frame_cnt), 4);
    run_frame(0, 0, -1, -1);
    check("clean_after_abort_err", int'(err), 0);
    check("clean_after_abort_cnt", int'(frame_cnt), 5);

    run_frame(1, 0, -1, 6);
    inject = 1;
    repeat (4) tick();
    check("idle_inject_err", int'(err), 1);
    run_frame(0, 0, -1, -1);
    check("post_reset_cnt", int'(frame_cnt), 1);

    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rdy_mode = 2;
    for (int f = 0; f < 256; f++) begin
      run_frame(0, 0, -1, -1);
      if (f == 254) check("cnt_255", int'(frame_cnt), 255);
    end
    check("cnt_wrap", int'(frame_cnt), 0);
    check("queue_drained", int'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/camera_ctrl.md
CAMERA_CTRL -- requirements
Module: camera_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 12, number of bytes per camera frame (range 2..255).
REQ-002 Parameter DATA_W, default 8, camera/pixel byte width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to capture one frame.
REQ-006 abort  input  1  cancel current frame, return to idle.
REQ-007 camera_en  output  1  enable to camera; camera returns byte k one cycle after its k-th enabled cycle.
REQ-008 cam_valid  input  1  camera data_valid.
REQ-009 cam_data  input  DATA_W  camera data_out.
REQ-010 out_valid  output  1  buffered byte available to filter.
REQ-011 out_ready  input  1  filter accepts byte when out_valid and out_ready both high.
REQ-012 out_data  output  DATA_W  buffered byte.
REQ-013 out_last  output  1  high with final byte of frame.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 frame_done  output  1  one-cycle pulse after last byte accepted.
REQ-016 err  output  1  sticky protocol error flag.
REQ-017 frame_cnt  output  8  completed-frame counter.

Function
REQ-018 The block SHALL implement states IDLE, CAPTURE, DRAIN, DONE in an internal buffer of FRAME_LEN x DATA_W registers.
REQ-019 IDLE: start=1 SHALL move to CAPTURE, clear err, and register camera_en=1 on the same edge.
REQ-020 CAPTURE: camera_en SHALL stay high for exactly FRAME_LEN consecutive cycles (en counter), then drop to 0.
REQ-021 CAPTURE: each cycle with cam_valid=1 and wr_ptr<FRAME_LEN SHALL write cam_data to buf[wr_ptr] and increment wr_ptr.
REQ-022 When the write making wr_ptr=FRAME_LEN occurs, the next state SHALL be DRAIN with rd_ptr=0.
REQ-023 cam_valid=1 in IDLE, DRAIN, DONE, or with wr_ptr=FRAME_LEN SHALL set err=1 and the byte SHALL be discarded.
REQ-024 DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==FRAME_LEN-1); on out_valid&out_ready rd_ptr SHALL increment.
REQ-025 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 Acceptance of the last byte SHALL move to DONE; DONE SHALL assert frame_done for one cycle, increment frame_cnt (wrap 255->0), then return to IDLE.
REQ-027 out_valid, out_last SHALL be 0 outside DRAIN; camera_en SHALL be 0 outside CAPTURE.
REQ-028 start while busy=1 SHALL be ignored (no restart, no error).
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge: camera_en=0, out_valid=0, pointers cleared, no frame_done, frame_cnt unchanged; abort has priority over start and out_ready in the same cycle.
REQ-030 First-byte capture-to-out_valid latency SHALL be: camera_en rise at edge N, cam_valid byte 0 at N+1, last byte at N+FRAME_LEN, out_valid high at N+FRAME_LEN+1.

Reset
REQ-031 rst_n=0 at a clock edge SHALL set state IDLE, camera_en=0, out_valid=0, out_last=0, out_data=0, busy=0, frame_done=0, err=0, frame_cnt=0, wr_ptr=rd_ptr=en counter=0; buffer contents need not be cleared.
REQ-032 Reset SHALL override start, abort and all other inputs, including mid-CAPTURE and mid-DRAIN.

Verification
REQ-033 start with camera model streaming BC,27,81,FF,CE,1F,E0,A9,38,2B,D4,11, out_ready=1 -> camera_en high exactly 12 cycles; out_data same 12 bytes in order, out_last with 11; frame_done one pulse; frame_cnt=1; err=0.
REQ-034 Same frame, out_ready toggled 1,0,0,1,... -> no byte lost or duplicated, out_data stable during stalls, frame_done only after byte 11 accepted.
REQ-035 start pulsed again in CAPTURE and DRAIN -> ignored; camera_en not re-extended; single frame_done.
REQ-036 abort after 5 bytes captured -> next cycle camera_en=0, busy=0, no frame_done, frame_cnt unchanged; subsequent start captures full clean frame.
REQ-037 rst_n=0 during DRAIN at rd_ptr=6 -> all outputs at reset values next cycle; cam_valid injected in IDLE -> err=1, cleared by next start.
REQ-038 256 back-to-back frames -> frame_cnt wraps 255->0 exactly on the 256th frame_done.
